mem_ctrl: RTL and testbench

- Byte-serial controller for the single 8-bit RAM port.
- Arbitrates between instruction fetch (word reads) and the MEM stage (byte/half/word loads and stores).
- Sequences multi-byte transfers and returns a one-cycle done pulse per request.
- Sits between the IF/MEM stages and the RAM. Requesters stall via the pipeline ctrl until done.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial RAM controller.
// Imported by mem_ctrl.
package mem_ctrl_pkg;

  localparam int BYTE_W  = 8;
  localparam int RAM_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] LenByte = 2'd0;
  localparam logic [1:0] LenHalf = 2'd1;
  localparam logic [1:0] LenWord = 2'd2;

  function automatic logic [2:0] len_to_n(
    input logic [1:0] len
  );
    logic [2:0] n;
    case (len)
      LenByte: n = 3'd1;
      LenHalf: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller for the single 8-bit RAM port.
// Serves fetch and MEM-stage requests, MEM first.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [BYTE_W-1:0] ram_dout,
  input  logic [BYTE_W-1:0] ram_din
);

  state_t            r_state;
  logic              r_src_mem;
  logic [ADDR_W-1:0] r_base;
  logic [2:0]        r_n;
  logic [31:0]       r_wdata;
  logic [2:0]        r_cnt;
  logic [31:0]       r_buf;
  logic [31:0]       r_if_data;
  logic [31:0]       r_mem_rdata;

  state_t            w_next;
  logic [2:0]        w_off;
  logic [1:0]        w_lane;
  logic [31:0]       w_rd_word;
  logic              w_rd_last;
  logic              w_wr_last;

  assign w_rd_last = (r_cnt == r_n);
  assign w_wr_last = (r_cnt == r_n - 3'd1);
  // Final read cycle re-presents the last byte's address.
  assign w_off  = (r_cnt < r_n) ? r_cnt : r_n - 3'd1;
  assign w_lane = 2'(r_cnt - 3'(RAM_LAT));

  always_comb begin
    w_rd_word = r_buf;
    w_rd_word[{w_lane, 3'b000} +: BYTE_W] = ram_din;
  end

  always_comb begin
    w_next   = r_state;
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = '0;
    if_done  = 1'b0;
    mem_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_req) begin
          w_next = mem_we ? WRITE : READ;
        end else if (if_req) begin
          w_next = READ;
        end
      end
      READ: begin
        ram_a = r_base + ADDR_W'(w_off);
        if (w_rd_last) w_next = DONE;
      end
      WRITE: begin
        ram_wr   = 1'b1;
        ram_a    = r_base + ADDR_W'(r_cnt);
        ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: BYTE_W];
        if (w_wr_last) w_next = DONE;
      end
      DONE: begin
        if_done  = !r_src_mem;
        mem_done = r_src_mem;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_src_mem   <= 1'b0;
      r_base      <= '0;
      r_n         <= 3'd0;
      r_wdata     <= '0;
      r_cnt       <= 3'd0;
      r_buf       <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_cnt <= 3'd0;
          r_buf <= '0;
          if (mem_req) begin
            r_src_mem <= 1'b1;
            r_base    <= mem_addr;
            r_n       <= len_to_n(mem_len);
            r_wdata   <= mem_wdata;
          end else if (if_req) begin
            r_src_mem <= 1'b0;
            r_base    <= if_addr;
            r_n       <= 3'd4;
            r_wdata   <= '0;
          end
        end
        READ: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt != 3'd0) r_buf <= w_rd_word;
          if (w_rd_last) begin
            if (r_src_mem) r_mem_rdata <= w_rd_word;
            else           r_if_data   <= w_rd_word;
          end
        end
        WRITE: r_cnt <= r_cnt + 3'd1;
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  assign if_data   = r_if_data;
  assign mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a 4 KiB byte RAM model.
// Stimulus pushes expectations; a negedge monitor pops on each done.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .ram_a(ram_a),
    .ram_wr(ram_wr), .ram_dout(ram_dout),
    .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input logic [11:0] a);
    case (a)
      12'h100: return 8'h11;
      12'h101: return 8'h22;
      12'h102: return 8'h33;
      12'h103: return 8'h44;
      12'h003: return 8'h80;
      12'h010: return 8'hA5;
      12'h011: return 8'h5A;
      12'hFFE: return 8'h01;
      12'hFFF: return 8'h02;
      12'h000: return 8'h03;
      12'h001: return 8'h04;
      default: return 8'h00;
    endcase
  endfunction

  bit         wv [4096];
  logic [7:0] wd [4096];

  function automatic logic [7:0] rd_ram(input logic [11:0] a);
    return wv[a] ? wd[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (ram_wr) begin
      wv[ram_a[11:0]] <= 1'b1;
      wd[ram_a[11:0]] <= ram_dout;
    end
    ram_din <= rd_ram(ram_a[11:0]);
  end

  logic [31:0] a_log [512];
  bit          w_log [512];
  always @(negedge clk) begin
    if (cyc < 512) begin
      a_log[cyc] <= ram_a;
      w_log[cyc] <= ram_wr;
    end
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check32(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (if_done) begin
        if (if_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL if_done_unexpected cyc=%0d", cyc);
        end else begin
          e = if_q.pop_front();
          check32("if_data", if_data, e.data);
          check32("if_done_cyc", 32'(cyc), 32'(e.cyc));
        end
      end
      if (mem_done) begin
        if (mem_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_done_unexpected cyc=%0d", cyc);
        end else begin
          e = mem_q.pop_front();
          if (e.chk) check32("mem_rdata", mem_rdata, e.data);
          check32("mem_done_cyc", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Both tasks are entered on a negedge; lat is cycles to the done cycle.
  task automatic if_op(input logic [31:0] a, input logic [31:0] d,
                       input int lat, output int acc);
    exp_t e;
    bit seen;
    acc = cyc + 1;
    if_req = 1'b1; if_addr = a;
    e.data = d; e.cyc = cyc + lat; e.chk = 1'b1;
    if_q.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = if_done;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL if_timeout act=no_done exp=done addr=%h", a);
    end
    if_req = 1'b0;
  endtask

  task automatic mem_op(input logic we, input logic [1:0] len,
                        input logic [31:0] a, input logic [31:0] wdat,
                        input logic [31:0] d, input int lat,
                        output int acc);
    exp_t e;
    bit seen;
    acc = cyc + 1;
    mem_req = 1'b1; mem_we = we; mem_len = len;
    mem_addr = a; mem_wdata = wdat;
    e.data = d; e.cyc = cyc + lat; e.chk = !we;
    mem_q.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = mem_done;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL mem_timeout act=no_done exp=done addr=%h", a);
    end
    mem_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    int wr_cnt;
    logic [31:0] exp_a [5];

    #1;
    check32("rst_if_done", 32'(if_done), 0);
    check32("rst_mem_done", 32'(mem_done), 0);
    check32("rst_if_data", if_data, 0);
    check32("rst_mem_rdata", mem_rdata, 0);
    check32("rst_ram_a", ram_a, 0);
    check32("rst_ram_wr", 32'(ram_wr), 0);
    check32("rst_ram_dout", 32'(ram_dout), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    if_op(32'h100, 32'h44332211, 6, acc);
    exp_a = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h103};
    for (int i = 0; i < 5; i++)
      check32($sformatf("fetch_ram_a%0d", i), a_log[acc + i], exp_a[i]);
    wr_cnt = 0;
    for (int i = 0; i < 6; i++) wr_cnt += int'(w_log[acc + i]);
    check32("fetch_no_wr", 32'(wr_cnt), 0);
    @(negedge clk);

    mem_op(1'b1, 2'd2, 32'h200, 32'hDEADBEEF, 32'h0, 5, acc);
    check32("st_b0", 32'(rd_ram(12'h200)), 32'hEF);
    check32("st_b1", 32'(rd_ram(12'h201)), 32'hBE);
    check32("st_b2", 32'(rd_ram(12'h202)), 32'hAD);
    check32("st_b3", 32'(rd_ram(12'h203)), 32'hDE);
    wr_cnt = 0;
    for (int i = 0; i < 6; i++) wr_cnt += int'(w_log[acc + i]);
    check32("st_wr_cycles", 32'(wr_cnt), 4);
    @(negedge clk);

    mem_op(1'b0, 2'd0, 32'h3, 32'h0, 32'h00000080, 3, acc);
    @(negedge clk);

    fork
      mem_op(1'b0, 2'd1, 32'h10, 32'h0, 32'h00005AA5, 4, acc);
      if_op(32'h100, 32'h44332211, 11, acc2);
    join
    @(negedge clk);

    if_op(32'hFFFFFFFE, 32'h04030201, 6, acc);
    exp_a = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h1};
    for (int i = 0; i < 5; i++)
      check32($sformatf("wrap_ram_a%0d", i), a_log[acc + i], exp_a[i]);
    @(negedge clk);

    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
    mem_addr = 32'h300; mem_wdata = 32'h11223344;
    repeat (3) @(negedge clk);
    check32("rstmid_wr_before", 32'(ram_wr), 1);
    rst = 1'b0;
    #1;
    check32("rstmid_wr_after", 32'(ram_wr), 0);
    check32("rstmid_no_done", 32'(mem_done), 0);
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check32("rstmid_b0", 32'(rd_ram(12'h300)), 32'h44);
    check32("rstmid_b1", 32'(rd_ram(12'h301)), 32'h33);
    check32("rstmid_b2", 32'(rd_ram(12'h302)), 32'h00);
    @(negedge clk);

    mem_op(1'b0, 2'd3, 32'h100, 32'h0, 32'h44332211, 6, acc);
    repeat (4) @(negedge clk);
    check32("if_q_empty", 32'(if_q.size()), 0);
    check32("mem_q_empty", 32'(mem_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
